// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: CPU memory-stage port, loader/debug port and single-ported memory side.
// The slave modport is the arbiter's view; master is the view of the requesters and memory.
interface dmem_arbiter_if #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned DMEM_POWER = 18
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [WORD_W-1:0]     cpu_addr;
  logic [WORD_W-1:0]     cpu_wdata;
  logic [WORD_W-1:0]     cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_fault;
  logic                  cpu_stall;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [WORD_W-1:0]     dbg_addr;
  logic [WORD_W-1:0]     dbg_wdata;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [WORD_W-1:0]     dbg_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [DMEM_POWER-1:0] mem_addr;
  logic [WORD_W-1:0]     mem_wdata;
  logic [WORD_W-1:0]     mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_fault, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_fault, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data memory between the CPU memory stage and a
// loader/debug port. One access in flight; misaligned CPU accesses complete at once with a fault.
module dmem_arbiter #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned DMEM_POWER = 18,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [2:0] LatInit = 3'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;  // 1: debug port owns the access
  logic              last_q, last_d;    // 1: debug port won the last grant
  logic              we_q, we_d;
  logic              fault_q, fault_d;
  logic [WORD_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WORD_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic                  gnt_cpu, gnt_dbg, cpu_misaligned;
  logic                  mem_en, mem_we;
  logic [DMEM_POWER-1:0] mem_addr;
  logic [WORD_W-1:0]     mem_wdata;
  logic                  cpu_ready;

  logic unused_addr;
  assign unused_addr = ^{bus.cpu_addr[WORD_W-1:DMEM_POWER+2],
                         bus.dbg_addr[WORD_W-1:DMEM_POWER+2], bus.dbg_addr[1:0]};

  assign cpu_misaligned = (bus.cpu_addr[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    fault_d     = fault_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    gnt_cpu     = 1'b0;
    gnt_dbg     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        // Grant is combinational, so it must also be blocked while reset is held.
        if (rst_ni) begin
          if (bus.cpu_req && (!bus.dbg_req || last_q)) begin
            gnt_cpu = 1'b1;
          end else if (bus.dbg_req) begin
            gnt_dbg = 1'b1;
          end
        end
        if (gnt_cpu || gnt_dbg) begin
          owner_d = gnt_dbg;
          last_d  = gnt_dbg;
          we_d    = gnt_dbg ? bus.dbg_we : bus.cpu_we;
          if (gnt_cpu && cpu_misaligned) begin
            fault_d     = 1'b1;
            cpu_rdata_d = '0;
            state_d     = StResp;
          end else begin
            fault_d   = 1'b0;
            mem_en    = 1'b1;
            mem_we    = we_d;
            mem_addr  = gnt_dbg ? bus.dbg_addr[DMEM_POWER+1:2] : bus.cpu_addr[DMEM_POWER+1:2];
            mem_wdata = gnt_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            cnt_d     = LatInit;
            state_d   = StBusy;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 3'd0) begin
          state_d = StResp;
          if (owner_q) begin
            dbg_rdata_d = we_q ? '0 : bus.mem_rdata;
          end else begin
            cpu_rdata_d = we_q ? '0 : bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
        fault_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      fault_q     <= fault_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_ready      = (state_q == StResp) && !owner_q;
  assign bus.cpu_ready  = cpu_ready;
  assign bus.cpu_fault  = cpu_ready && fault_q;
  assign bus.cpu_stall  = bus.cpu_req && !cpu_ready;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_gnt    = gnt_dbg;
  assign bus.dbg_rvalid = (state_q == StResp) && owner_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a two-cycle-latency memory model; every expected value
// below is hand-derived from the cycle-T timing of a grant.
module tb_dmem_arbiter;

  logic clk_i;
  logic rst_ni;
  int   errors;
  int   checks;

  dmem_arbiter_if #(.WORD_W(32), .DMEM_POWER(18)) bus ();

  dmem_arbiter #(.WORD_W(32), .DMEM_POWER(18), .MEM_LAT(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Memory model: word 4 = DEADBEEF, other unwritten words = CAFE0000 | index.
  logic [31:0] mem [16];
  bit   [15:0] wr_valid;
  logic [31:0] rd1, rd2;

  function automatic logic [31:0] rd_word(input logic [3:0] idx);
    if (wr_valid[idx]) return mem[idx];
    if (idx == 4'd4) return 32'hDEADBEEF;
    return 32'hCAFE0000 | {28'd0, idx};
  endfunction

  always @(posedge clk_i) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[3:0]]      <= bus.mem_wdata;
      wr_valid[bus.mem_addr[3:0]] <= 1'b1;
    end
    rd1 <= (bus.mem_en && !bus.mem_we) ? rd_word(bus.mem_addr[3:0]) : 32'hBAD0BAD0;
    rd2 <= rd1;
  end
  assign bus.mem_rdata = rd2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  // Full aligned CPU access from grant cycle T to the ready cycle T+3; leaves cpu_req high.
  task automatic cpu_access(input string tag, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic [31:0] exp_maddr,
                            input logic [31:0] exp_rdata);
    adv();
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    #1;
    chk({tag, "_T_mem_en"}, {31'd0, bus.mem_en}, 32'd1);
    chk({tag, "_T_mem_addr"}, {14'd0, bus.mem_addr}, exp_maddr);
    chk({tag, "_T_mem_we"}, {31'd0, bus.mem_we}, {31'd0, we});
    chk({tag, "_T_mem_wdata"}, bus.mem_wdata, wdata);
    chk({tag, "_T_stall"}, {31'd0, bus.cpu_stall}, 32'd1);
    for (int k = 1; k <= 2; k++) begin
      adv(); #1;
      chk({tag, "_busy_mem_en"}, {31'd0, bus.mem_en}, 32'd0);
      chk({tag, "_busy_ready"}, {31'd0, bus.cpu_ready}, 32'd0);
      chk({tag, "_busy_stall"}, {31'd0, bus.cpu_stall}, 32'd1);
    end
    adv(); #1;
    chk({tag, "_ready"}, {31'd0, bus.cpu_ready}, 32'd1);
    chk({tag, "_fault"}, {31'd0, bus.cpu_fault}, 32'd0);
    chk({tag, "_rdata"}, bus.cpu_rdata, exp_rdata);
    chk({tag, "_stall_rel"}, {31'd0, bus.cpu_stall}, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_ni = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0;    bus.dbg_wdata = '0;
    #2;
    // Reset held with a CPU request pending: nothing may be granted.
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_addr", {14'd0, bus.mem_addr}, 32'd0);
    chk("rst_ready", {31'd0, bus.cpu_ready}, 32'd0);
    chk("rst_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    adv(); adv();
    chk("rst_mem_en_held", {31'd0, bus.mem_en}, 32'd0);
    bus.cpu_req = 1'b0;
    rst_ni = 1'b1;

    // Both requesting continuously: cpu, dbg, cpu, dbg, four cycles each.
    adv();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h21;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("rr_mem_en", {31'd0, bus.mem_en}, {31'd0, (i % 4) == 0});
      chk("rr_dbg_gnt", {31'd0, bus.dbg_gnt}, {31'd0, (i % 4) == 0 && ((i / 4) % 2) == 1});
      chk("rr_cpu_ready", {31'd0, bus.cpu_ready}, {31'd0, (i % 4) == 3 && ((i / 4) % 2) == 0});
      chk("rr_dbg_rvalid", {31'd0, bus.dbg_rvalid}, {31'd0, (i % 4) == 3 && ((i / 4) % 2) == 1});
      if ((i % 4) == 0) chk("rr_mem_addr", {14'd0, bus.mem_addr}, ((i / 4) % 2) ? 32'd8 : 32'd4);
      if ((i % 4) == 3 && ((i / 4) % 2) == 0) chk("rr_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
      if ((i % 4) == 3 && ((i / 4) % 2) == 1) chk("rr_dbg_rdata", bus.dbg_rdata, 32'hCAFE0008);
      if (i < 15) adv();
    end
    adv();
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    #1;

    // Aligned load, then store/load to the same word.
    cpu_access("load10", 32'h10, 1'b0, 32'h0, 32'd4, 32'hDEADBEEF);
    adv();
    bus.cpu_req = 1'b0;
    #1;
    chk("load10_ready_drop", {31'd0, bus.cpu_ready}, 32'd0);
    chk("load10_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);
    chk("dbg_rdata_hold", bus.dbg_rdata, 32'hCAFE0008);
    cpu_access("store20", 32'h20, 1'b1, 32'h1234, 32'd8, 32'h0);
    cpu_access("load20", 32'h20, 1'b0, 32'h0, 32'd8, 32'h1234);

    // Reset one cycle into a load abandons it.
    adv();
    bus.cpu_req = 1'b0;
    #1;
    adv();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    #1;
    chk("rstmid_T_mem_en", {31'd0, bus.mem_en}, 32'd1);
    adv();
    rst_ni = 1'b0;
    #1;
    chk("rstmid_ready", {31'd0, bus.cpu_ready}, 32'd0);
    chk("rstmid_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rstmid_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rstmid_fault", {31'd0, bus.cpu_fault}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      adv(); #1;
      chk("rstmid_no_ready", {31'd0, bus.cpu_ready}, 32'd0);
    end
    bus.cpu_req = 1'b0;
    rst_ni = 1'b1;
    cpu_access("reissue", 32'h10, 1'b0, 32'h0, 32'd4, 32'hDEADBEEF);

    // Misaligned CPU load faults without touching memory.
    adv();
    bus.cpu_req = 1'b0;
    #1;
    adv();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h13;
    #1;
    chk("mis_T_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("mis_T_stall", {31'd0, bus.cpu_stall}, 32'd1);
    adv(); #1;
    chk("mis_ready", {31'd0, bus.cpu_ready}, 32'd1);
    chk("mis_fault", {31'd0, bus.cpu_fault}, 32'd1);
    chk("mis_rdata", bus.cpu_rdata, 32'd0);
    chk("mis_mem_en", {31'd0, bus.mem_en}, 32'd0);
    adv();
    bus.cpu_req = 1'b0;
    #1;
    chk("mis_fault_clr", {31'd0, bus.cpu_fault}, 32'd0);
    chk("mis_ready_clr", {31'd0, bus.cpu_ready}, 32'd0);

    // Debug request arriving while the CPU is busy waits for the next idle cycle.
    adv();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
    #1;
    chk("wait_cpu_mem_en", {31'd0, bus.mem_en}, 32'd1);
    adv();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h12;
    #1;
    chk("wait_gnt_busy1", {31'd0, bus.dbg_gnt}, 32'd0);
    adv(); #1;
    chk("wait_gnt_busy2", {31'd0, bus.dbg_gnt}, 32'd0);
    adv(); #1;
    chk("wait_cpu_ready", {31'd0, bus.cpu_ready}, 32'd1);
    chk("wait_gnt_resp", {31'd0, bus.dbg_gnt}, 32'd0);
    adv();
    bus.cpu_req = 1'b0;
    #1;
    chk("wait_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    chk("wait_dbg_mem_en", {31'd0, bus.mem_en}, 32'd1);
    chk("wait_dbg_mem_addr", {14'd0, bus.mem_addr}, 32'd4);
    for (int k = 0; k < 2; k++) begin
      adv(); #1;
      chk("wait_dbg_gnt_once", {31'd0, bus.dbg_gnt}, 32'd0);
      chk("wait_rvalid_early", {31'd0, bus.dbg_rvalid}, 32'd0);
    end
    adv(); #1;
    chk("wait_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
    chk("wait_dbg_rdata", bus.dbg_rdata, 32'hDEADBEEF);
    chk("wait_cpu_ready_none", {31'd0, bus.cpu_ready}, 32'd0);
    adv();
    bus.dbg_req = 1'b0;
    #1;
    chk("wait_rvalid_drop", {31'd0, bus.dbg_rvalid}, 32'd0);

    // Debug write: forced word alignment, zero response data.
    adv();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h0D; bus.dbg_wdata = 32'hA5A5;
    #1;
    chk("dbgwr_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    chk("dbgwr_mem_we", {31'd0, bus.mem_we}, 32'd1);
    chk("dbgwr_mem_addr", {14'd0, bus.mem_addr}, 32'd3);
    chk("dbgwr_mem_wdata", bus.mem_wdata, 32'hA5A5);
    adv(); adv(); adv();
    chk("dbgwr_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
    chk("dbgwr_rdata", bus.dbg_rdata, 32'd0);
    adv();
    bus.dbg_req = 1'b0;
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data/address word width.
REQ-002 SHALL have parameter DMEM_POWER, default 18, log2 of data-memory depth in words.
REQ-003 SHALL have parameter MEM_LAT, default 2, data-memory read latency in cycles, legal 1..7.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
REQ-006 cpu_req / cpu_we  in  1 / 1  memory-stage access request / write enable.
REQ-007 cpu_addr / cpu_wdata  in  WORD_W / WORD_W  byte address (ALU result) / store data.
REQ-008 cpu_rdata / cpu_ready / cpu_fault  out  WORD_W / 1 / 1  load data / one-cycle completion / misaligned-access flag.
REQ-009 cpu_stall  out  1  pipeline hold; drives pipeline register enable low.
REQ-010 dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1 / 1 / WORD_W / WORD_W  loader/debug port request.
REQ-011 dbg_gnt / dbg_rvalid / dbg_rdata  out  1 / 1 / WORD_W  accept pulse / completion pulse / load data.
REQ-012 mem_en / mem_we  out  1 / 1  one-cycle memory strobe / write.
REQ-013 mem_addr / mem_wdata / mem_rdata  out / out / in  DMEM_POWER / WORD_W / WORD_W  word index, store data, read data.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, RESP; only IDLE accepts requests.
REQ-015 In IDLE with one requester, that requester SHALL be granted in the same cycle (cycle T).
REQ-016 In IDLE with both requesting, grant SHALL alternate round-robin via last-grant flag; after reset, cpu wins first.
REQ-017 At grant, mem_en=1 for exactly cycle T; mem_addr=addr[DMEM_POWER+1:2]; mem_we=we; mem_wdata=wdata; owner, we latched.
REQ-018 dbg_gnt SHALL pulse high for cycle T only when dbg is granted.
REQ-019 Latency counter (3 bits) SHALL load MEM_LAT-1 at T; BUSY decrements each cycle.
REQ-020 BUSY with counter 0 SHALL capture mem_rdata into response register and go to RESP (cycle T+MEM_LAT).
REQ-021 RESP (cycle T+MEM_LAT+1) SHALL pulse owner's cpu_ready or dbg_rvalid for one cycle, then return to IDLE.
REQ-022 Writes SHALL follow identical timing; response data for a write SHALL be 0.
REQ-023 cpu_rdata/dbg_rdata SHALL hold last response value until next response of that port.
REQ-024 cpu_stall SHALL equal cpu_req AND NOT cpu_ready, combinationally.
REQ-025 cpu_addr[1:0]!=0 at grant SHALL suppress mem_en, go directly IDLE->RESP, pulse cpu_ready with cpu_fault=1, rdata 0; cpu_fault else 0.
REQ-026 Debug addresses SHALL ignore addr[1:0] (forced word alignment, no fault).
REQ-027 Requesters SHALL hold req and operands stable until completion; deassertion mid-transaction SHALL NOT abort it.
REQ-028 A request arriving in BUSY/RESP SHALL wait until IDLE; no request is lost or duplicated.

Reset
REQ-029 reset low SHALL immediately force IDLE, counter 0, last-grant=dbg, all strobes (mem_en, dbg_gnt, cpu_ready, dbg_rvalid, cpu_fault) 0, rdata registers 0, mem_addr/mem_wdata/mem_we 0.
REQ-030 Reset mid-transaction SHALL abandon it with no completion pulse; re-issue after release starts fresh at IDLE.

Verification
REQ-031 cpu load addr 0x10, MEM_LAT=2, mem word 4 = 0xDEADBEEF -> mem_en at T with mem_addr 4; cpu_ready and cpu_rdata=0xDEADBEEF at T+3; cpu_stall high T..T+2.
REQ-032 cpu store addr 0x20 data 0x1234, then load 0x20 -> second access returns 0x1234; first ready with rdata 0.
REQ-033 cpu and dbg both requesting continuously after reset -> grants cpu, dbg, cpu, dbg; each completes exactly once per grant.
REQ-034 cpu load addr 0x13 -> no mem_en; cpu_ready and cpu_fault=1 at T+1, cpu_rdata=0.
REQ-035 reset asserted at T+1 of a load -> no cpu_ready pulse; all outputs 0 asynchronously; after release same request completes at new T+MEM_LAT+1.
REQ-036 dbg request during cpu BUSY -> dbg_gnt exactly on first IDLE cycle after cpu_ready.
